// File: rtl/seven_seg_scroller.sv
// Message buffer that scrolls its characters right-to-left across a four-digit
// seven-segment window, one position per TICK_DIV cycles, optionally looping.
module seven_seg_scroller #(
    parameter int         DEPTH    = 16,
    parameter int         TICK_DIV = 25_000_000,
    parameter logic [4:0] PAD      = 5'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [4:0] wr_data,
    output logic       wr_ready,
    input  logic       clear,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    output logic       busy,
    output logic       step,
    output logic [4:0] digits0,
    output logic [4:0] digits1,
    output logic [4:0] digits2,
    output logic [4:0] digits3
);

    localparam int AW     = $clog2(DEPTH);
    localparam int LEN_W  = $clog2(DEPTH + 1);
    localparam int POS_W  = $clog2(DEPTH + 3);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        SCROLL = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [4:0]         msg_q [DEPTH];
    logic [4:0]         msg_d [DEPTH];
    logic [AW-1:0]      wr_idx;
    logic [POS_W-1:0]   end_pos;
    logic [POS_W:0]     win_idx [4];
    logic [4:0]         win [4];

    assign busy    = (state_q == SCROLL);
    assign digits0 = win[0];
    assign digits1 = win[1];
    assign digits2 = win[2];
    assign digits3 = win[3];

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        pos_d    = pos_q;
        tick_d   = tick_q;
        msg_d    = msg_q;
        wr_ready = (state_q == IDLE) && (len_q < LEN_W'(DEPTH));
        step     = (state_q == SCROLL) && (tick_q == TICK_W'(TICK_DIV - 1));
        // A write alongside clear lands at slot 0 of the freshly emptied buffer.
        wr_idx   = clear ? '0 : len_q[AW-1:0];
        end_pos  = POS_W'(len_q) + POS_W'(2);

        case (state_q)
            IDLE: begin
                if (clear) begin
                    len_d = '0;
                end
                if (wr_en && wr_ready) begin
                    msg_d[wr_idx] = wr_data;
                    len_d         = len_d + LEN_W'(1);
                end
                if (start && !clear && (len_d != '0)) begin
                    state_d = SCROLL;
                    pos_d   = '0;
                    tick_d  = '0;
                end
            end
            SCROLL: begin
                if (stop) begin
                    state_d = IDLE;
                    pos_d   = '0;
                    tick_d  = '0;
                end else if (step) begin
                    tick_d = '0;
                    if (pos_q == end_pos) begin
                        pos_d = '0;
                        if (!loop) begin
                            state_d = IDLE;
                        end
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Window digit k shows msg[pos-k]; a set MSB of the difference means pos < k.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            win_idx[k] = {1'b0, pos_q} - (POS_W + 1)'(k);
            win[k]     = PAD;
            if ((state_q == SCROLL) && !win_idx[k][POS_W] &&
                (win_idx[k][POS_W-1:0] < POS_W'(len_q))) begin
                win[k] = msg_q[win_idx[k][AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            pos_q   <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pos_q   <= pos_d;
            tick_q  <= tick_d;
        end
    end

    always_ff @(posedge clk) begin
        msg_q <= msg_d;
    end

endmodule

// File: tb/tb_seven_seg_scroller.sv
// Directed bench for seven_seg_scroller with DEPTH=8, TICK_DIV=4, PAD=0:
// scroll windows, fill limit, looping, stop, simultaneous events and reset.
module tb_seven_seg_scroller;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [4:0] wr_data;
    logic       wr_ready;
    logic       clear;
    logic       start;
    logic       stop;
    logic       loop;
    logic       busy;
    logic       step;
    logic [4:0] digits0, digits1, digits2, digits3;

    int errors;
    int checks;
    int step_cnt;

    seven_seg_scroller #(
        .DEPTH    (8),
        .TICK_DIV (4),
        .PAD      (5'h00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .clear    (clear),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .busy     (busy),
        .step     (step),
        .digits0  (digits0),
        .digits1  (digits1),
        .digits2  (digits2),
        .digits3  (digits3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n edges; sample 1 ns after each edge and tally step pulses.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (step === 1'b1) step_cnt++;
        end
    endtask

    task automatic check_win(input string tag, input logic [19:0] exp);
        check_val(tag, {digits3, digits2, digits1, digits0}, {12'h0, exp});
    endtask

    task automatic do_write(input logic [4:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        cyc(1);
        wr_en   = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        step_cnt = 0;
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; clear = 1'b0;
        start = 1'b0; stop = 1'b0; loop = 1'b0;

        // Reset state
        cyc(2);
        check_val("rst_busy", busy, 0);
        check_val("rst_ready", wr_ready, 1);
        check_val("rst_step", step, 0);
        check_win("rst_digits", 20'h0);
        reset = 1'b0;
        cyc(1);

        // Basic three-character pass
        do_write(5'h01);
        do_write(5'h02);
        do_write(5'h03);
        step_cnt = 0;
        do_start;
        check_val("basic_busy", busy, 1);
        check_val("basic_ready_scroll", wr_ready, 0);
        check_win("basic_n0", {5'h00, 5'h00, 5'h00, 5'h01});
        cyc(4);
        check_win("basic_n4", {5'h00, 5'h00, 5'h01, 5'h02});
        cyc(8);
        check_win("basic_n12", {5'h01, 5'h02, 5'h03, 5'h00});
        cyc(11);
        check_val("basic_busy_n23", busy, 1);
        cyc(1);
        check_val("basic_busy_n24", busy, 0);
        check_win("basic_n24", 20'h0);
        check_val("basic_steps", step_cnt, 6);

        // Fill: nine writes, eight accepted
        do_clear;
        for (int i = 0; i < 9; i++) begin
            wr_en   = 1'b1;
            wr_data = 5'(5'h11 + i);
            cyc(1);
            if (i == 6) check_val("fill_ready7", wr_ready, 1);
            if (i == 7) check_val("fill_ready8", wr_ready, 0);
        end
        wr_en = 1'b0;
        check_val("fill_ready_end", wr_ready, 0);
        step_cnt = 0;
        do_start;
        check_win("fill_p0", {5'h00, 5'h00, 5'h00, 5'h11});
        cyc(28);
        check_win("fill_p7", {5'h15, 5'h16, 5'h17, 5'h18});
        cyc(4);
        check_win("fill_p8", {5'h16, 5'h17, 5'h18, 5'h00});
        cyc(11);
        check_val("fill_busy_n43", busy, 1);
        cyc(1);
        check_val("fill_busy_n44", busy, 0);
        check_val("fill_steps", step_cnt, 11);

        // Looping pass with len=2, then stop and replay
        do_clear;
        do_write(5'h0A);
        do_write(5'h0B);
        loop = 1'b1;
        do_start;
        cyc(16);
        check_win("loop_p4", {5'h0B, 5'h00, 5'h00, 5'h00});
        cyc(4);
        check_win("loop_wrap", {5'h00, 5'h00, 5'h00, 5'h0A});
        check_val("loop_busy", busy, 1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check_val("stop_busy", busy, 0);
        check_win("stop_digits", 20'h0);
        loop = 1'b0;
        do_start;
        check_win("replay_p0", {5'h00, 5'h00, 5'h00, 5'h0A});
        cyc(4);
        check_win("replay_p1", {5'h00, 5'h00, 5'h0A, 5'h0B});
        cyc(16);
        check_val("replay_done", busy, 0);

        // Start with empty buffer
        do_clear;
        do_start;
        check_val("empty_start", busy, 0);

        // Clear together with a write leaves only the new character
        do_write(5'h01);
        do_write(5'h02);
        clear = 1'b1; wr_en = 1'b1; wr_data = 5'h07;
        cyc(1);
        clear = 1'b0; wr_en = 1'b0;
        do_start;
        check_win("clrwr_p0", {5'h00, 5'h00, 5'h00, 5'h07});
        // Write during scroll must be dropped
        wr_en = 1'b1; wr_data = 5'h1F;
        cyc(1);
        wr_en = 1'b0;
        cyc(3);
        check_win("scroll_wr_drop", {5'h00, 5'h00, 5'h07, 5'h00});
        cyc(12);
        check_val("clrwr_done", busy, 0);

        // Start with clear is ignored
        start = 1'b1; clear = 1'b1;
        cyc(1);
        start = 1'b0; clear = 1'b0;
        check_val("start_clear", busy, 0);

        // Start with an accepted write scrolls the new character
        start = 1'b1; wr_en = 1'b1; wr_data = 5'h03;
        cyc(1);
        start = 1'b0; wr_en = 1'b0;
        check_val("start_wr_busy", busy, 1);
        check_win("start_wr_p0", {5'h00, 5'h00, 5'h00, 5'h03});
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;

        // Reset mid-scroll
        do_write(5'h04);
        do_start;
        cyc(12);
        check_win("mid_p3", {5'h03, 5'h04, 5'h00, 5'h00});
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_ready", wr_ready, 1);
        check_win("midrst_digits", 20'h0);
        do_start;
        check_val("midrst_len0", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scroller.md
# seven_seg_scroller

Message sequencer for the four-digit seven-segment display path. Software or upstream logic loads a short character message into an internal buffer through a write handshake. The block then scrolls the message right-to-left across the four display digits at a programmable rate, optionally looping. Its `digits0..digits3` outputs connect directly to the inputs of `seven_seg_controller`, with `digits3` as the leftmost digit.

## Interface
- `DEPTH`, 16: message buffer capacity in characters; power of two, ≥ 4.
- `TICK_DIV`, 25_000_000: clock cycles per scroll step; ≥ 1.
- `PAD`, 5'h00: character code shown in digit positions outside the message.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `wr_en` in 1: append `wr_data` to the buffer; accepted only when `wr_ready` is high.
- `wr_data` in 5: character code {dp, hex nibble}.
- `wr_ready` out 1: write can be accepted (IDLE and buffer not full).
- `clear` in 1: empty the buffer; honoured in IDLE only.
- `start` in 1: begin scrolling; honoured in IDLE with a non-empty buffer.
- `stop` in 1: abort scrolling; honoured in SCROLL only.
- `loop` in 1: sampled at the end of each pass; 1 restarts the pass, 0 ends it.
- `busy` out 1: high in SCROLL.
- `step` out 1: one-cycle pulse on every scroll position advance.
- `digits0`, `digits1`, `digits2`, `digits3` out 5 each: display window; `digits0` is rightmost.

## Operation
- Registers:
  - `buf[0..DEPTH-1]`: 5 bits each.
  - `len`: clog2(DEPTH+1) bits.
  - `pos`: clog2(DEPTH+3) bits.
  - `tick`: clog2(TICK_DIV) bits, minimum 1.
  - `state`: IDLE or SCROLL.
- IDLE:
  - `wr_ready = (len < DEPTH)`.
  - A write accepted with `wr_en & wr_ready` stores `buf[len] <= wr_data` and sets `len <= len+1`.
  - Writes while full or in SCROLL are dropped silently; `buf` and `len` are unchanged.
  - `clear` sets `len <= 0`.
  - `start` with post-update `len > 0` and no `clear` transitions to SCROLL with `pos <= 0` and `tick <= 0`.
  - All digits show `PAD`.
- SCROLL:
  - `wr_ready = 0`; `clear` and `start` are ignored.
  - `tick` counts 0..TICK_DIV-1. When `tick == TICK_DIV-1`, a step occurs: `tick <= 0` and `step` pulses.
  - On a step with `pos < len+2`: `pos <= pos+1`.
  - On a step with `pos == len+2` (end of pass):
    - `loop = 1`: `pos <= 0`, remain in SCROLL.
    - `loop = 0`: go to IDLE.
  - `stop` goes to IDLE on the next edge and takes priority over a simultaneous step. `buf` and `len` are retained, so a new `start` replays the message.
- Display window, for k = 0..3: `digits_k = buf[pos-k]` if 0 ≤ pos-k < len, else `PAD`. Signed comparison; no wrap-around indexing.
- Resulting pass: the message enters at `digits0`, moves left one digit per step, and exits past `digits3`. A pass has `len+3` positions.
- Simultaneous IDLE events, in priority order:
  - `clear` with `wr_en`: clear takes effect, then the write lands at index 0, giving `len = 1`.
  - `start` with `clear`: start is ignored.
  - `start` with an accepted write: scrolling covers the new `len` including that character.
- Reset:
  - State: `state = IDLE`, `len = 0`, `pos = 0`, `tick = 0`.
  - Outputs: `busy = 0`, `step = 0`, `wr_ready = 1`, all digits `PAD`.
  - Buffer contents are don't-care after reset.
  - Reset overrides every other input, including mid-scroll.

## Timing
- `busy`, `step`, `wr_ready` and the digits are functions of registered state only; they have no combinational path from inputs.
- A `start` sampled at edge N gives `busy = 1` and the window at `pos = 0` from edge N, i.e. `digits0 = buf[0]` in the cycle after N.
- The first step occurs TICK_DIV edges after N.
- A non-looping pass ends at edge N + (len+3)·TICK_DIV: `busy` falls and all digits show `PAD`.
- A `stop` sampled at edge M gives `busy = 0` after M.
- `wr_ready` drops in the cycle after the DEPTH-th accepted write.
- Throughput: one write per cycle.

## Test plan
All scenarios use DEPTH=8, TICK_DIV=4, PAD=5'h00.
- Reset: assert `reset` 2 cycles → `busy=0`, `wr_ready=1`, `step=0`, all digits `00`.
- Write `01`, `02`, `03`, then `start` at edge N:
  - Cycle after N: `digits0=01`, others `00`.
  - N+4: `digits1=01`, `digits0=02`.
  - N+12: `digits3=01`, `digits2=02`, `digits1=03`.
  - N+24: `busy=0`, all digits `00`.
  - Exactly 6 `step` pulses in total.
- Fill: 9 consecutive writes → the first 8 are accepted, `wr_ready=0` after the 8th, the 9th is dropped. A following scroll shows only those 8 characters; a pass is 11 steps.
- `loop=1` with `len=2`:
  - After 5 steps, `pos` wraps: `digits0=buf[0]` and `busy` stays 1.
  - `stop` pulse → `busy=0` on the next edge; a new `start` replays the same message.
- Edge events:
  - `start` with empty buffer → stays IDLE.
  - `clear` with `wr_en` (`wr_data=07`) → `len=1`.
  - `start` in the same cycle as `clear` → ignored.
  - `wr_en` during SCROLL → dropped.
- Reset mid-scroll at step 3 → next cycle IDLE, `busy=0`, `len=0`, all digits `00`.
